// File: rtl/divrem_sequencer.sv
// -----------------------------------------------------------------------------
// divrem_sequencer
//
// EX-stage controller for the shared iterative divider (DIV/DIVU/REM/REMU).
// Accepts a divide-class instruction in EX and latches its operands. It
// resolves the RISC-V corner cases locally: divide by zero and signed
// overflow. All other operations go to the divider core as a one-cycle start
// pulse. The controller then waits for the core's ready pulse, stalling EX,
// and presents the selected quotient/remainder for the advance cycle. A
// watchdog forces completion (result 0, sticky oTimeout) if the core never
// answers.
//
// Optional build macro: DIVREM_REUSE_EN
//   Remembers the last core result with its {A, B, signed} tag. A following
//   op on the same operands (e.g. DIV then REM) completes without the core.
//
// Ports
//   iCLK, iRST           clock, asynchronous active-high reset
//   iEX_DivRem           EX holds a divide-class instruction
//   iEX_Funct3           100 DIV, 101 DIVU, 110 REM, 111 REMU
//   iEX_OpA / iEX_OpB    dividend / divisor (post-forward)
//   iHold                external pipeline stall; result held in DONE
//   iFlush               EX flush; abort current operation
//   iUnitReady           core result valid (single-cycle pulse)
//   iUnitQuot/iUnitRem   core quotient / remainder
//   oUnitStart           one-cycle start pulse to core
//   oUnitAbort           one-cycle abort pulse to core
//   oUnitSigned          signed mode for core
//   oUnitA / oUnitB      latched dividend / divisor
//   oStall               stall request to hazard unit
//   oResult              selected quotient/remainder
//   oResultValid         result valid for EX->MEM
//   oTimeout             sticky watchdog flag
// -----------------------------------------------------------------------------
module divrem_sequencer #(
  parameter int MAX_CYCLES = 40,
  parameter int CW         = 6
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEX_DivRem,
  input  logic [2:0]  iEX_Funct3,
  input  logic [31:0] iEX_OpA,
  input  logic [31:0] iEX_OpB,
  input  logic        iHold,
  input  logic        iFlush,
  input  logic        iUnitReady,
  input  logic [31:0] iUnitQuot,
  input  logic [31:0] iUnitRem,
  output logic        oUnitStart,
  output logic        oUnitAbort,
  output logic        oUnitSigned,
  output logic [31:0] oUnitA,
  output logic [31:0] oUnitB,
  output logic        oStall,
  output logic [31:0] oResult,
  output logic        oResultValid,
  output logic        oTimeout
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t      state, nextState;
  logic [CW-1:0] waitCnt;
  logic [31:0] aQ, bQ, resultQ;
  logic        signedQ, selRemQ, timeoutQ;

  // Decode of the instruction currently in EX (only meaningful in IDLE).
  logic opSigned, opSelRem, accept, divByZero, signedOvf, coreDone, timeoutHit;
  logic reuseHit;

  // funct3[2] is always 1 for this instruction class; iEX_DivRem qualifies it.
  logic unusedFunct3;
  assign unusedFunct3 = iEX_Funct3[2];

  assign opSigned   = ~iEX_Funct3[0];
  assign opSelRem   = iEX_Funct3[1];
  assign accept     = (state == IDLE) && iEX_DivRem && !iFlush;
  assign divByZero  = (iEX_OpB == 32'h0);
  assign signedOvf  = opSigned && (iEX_OpA == 32'h8000_0000) && (iEX_OpB == 32'hFFFF_FFFF);
  // Flush takes priority over a coincident ready or watchdog expiry.
  assign coreDone   = (state == WAIT) && iUnitReady && !iFlush;
  assign timeoutHit = (state == WAIT) && !iUnitReady && !iFlush &&
                      (waitCnt == CW'(MAX_CYCLES - 1));

`ifdef DIVREM_REUSE_EN
  logic [31:0] lastQuot, lastRem, tagA, tagB;
  logic        tagSigned, reuseValid;

  assign reuseHit = reuseValid && (tagA == iEX_OpA) && (tagB == iEX_OpB) &&
                    (tagSigned == opSigned);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      lastQuot   <= '0;
      lastRem    <= '0;
      tagA       <= '0;
      tagB       <= '0;
      tagSigned  <= 1'b0;
      reuseValid <= 1'b0;
    end else if (coreDone) begin
      lastQuot   <= iUnitQuot;
      lastRem    <= iUnitRem;
      tagA       <= aQ;
      tagB       <= bQ;
      tagSigned  <= signedQ;
      reuseValid <= 1'b1;
    end else if (timeoutHit) begin
      reuseValid <= 1'b0;
    end
  end
`else
  assign reuseHit = 1'b0;
`endif

  // State register.
  always_ff @(posedge iCLK or posedge iRST) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves nextState unassigned (no latch).
    nextState = state;
    unique case (state)
      IDLE:  if (accept) nextState = (divByZero || signedOvf || reuseHit) ? DONE : START;
      START: nextState = WAIT;
      WAIT:  if (coreDone || timeoutHit) nextState = DONE;
      DONE:  if (!iHold) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (iFlush) nextState = IDLE;
  end

  // Operand latch, result capture, watchdog counter, sticky timeout.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      aQ       <= '0;
      bQ       <= '0;
      signedQ  <= 1'b0;
      selRemQ  <= 1'b0;
      resultQ  <= '0;
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
    end else begin
      if (accept) begin
        aQ      <= iEX_OpA;
        bQ      <= iEX_OpB;
        signedQ <= opSigned;
        selRemQ <= opSelRem;
        if (divByZero)      resultQ <= opSelRem ? iEX_OpA : 32'hFFFF_FFFF;
        else if (signedOvf) resultQ <= opSelRem ? 32'h0 : 32'h8000_0000;
`ifdef DIVREM_REUSE_EN
        else if (reuseHit)  resultQ <= opSelRem ? lastRem : lastQuot;
`endif
      end
      if (state == START) waitCnt <= '0;
      else if (state == WAIT) waitCnt <= waitCnt + 1'b1;
      if (coreDone) resultQ <= selRemQ ? iUnitRem : iUnitQuot;
      if (timeoutHit) begin
        resultQ  <= '0;
        timeoutQ <= 1'b1;
      end
    end
  end

  // Output logic.
  always_comb begin
    oUnitStart   = (state == START);
    oUnitAbort   = (((state == START) || (state == WAIT)) && iFlush) || timeoutHit;
    oResultValid = (state == DONE);
    oStall       = iEX_DivRem && (state != DONE);
    oUnitSigned  = signedQ;
    oUnitA       = aQ;
    oUnitB       = bQ;
    oResult      = resultQ;
    oTimeout     = timeoutQ;
  end

endmodule

// File: tb/tb_divrem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_divrem_sequencer
//
// Directed bench for divrem_sequencer. Each operation pushes its expected
// result, stall count, start count and abort count to a scoreboard queue. The
// entry is popped and compared when the DUT raises oResultValid. The divider
// core is modelled by pulsing iUnitReady in a chosen WAIT cycle.
// -----------------------------------------------------------------------------
module tb_divrem_sequencer;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iEX_DivRem;
  logic [2:0]  iEX_Funct3;
  logic [31:0] iEX_OpA, iEX_OpB;
  logic        iHold, iFlush, iUnitReady;
  logic [31:0] iUnitQuot, iUnitRem;
  logic        oUnitStart, oUnitAbort, oUnitSigned;
  logic [31:0] oUnitA, oUnitB;
  logic        oStall;
  logic [31:0] oResult;
  logic        oResultValid, oTimeout;

  divrem_sequencer #(.MAX_CYCLES(40), .CW(6)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iEX_DivRem(iEX_DivRem), .iEX_Funct3(iEX_Funct3),
    .iEX_OpA(iEX_OpA), .iEX_OpB(iEX_OpB),
    .iHold(iHold), .iFlush(iFlush),
    .iUnitReady(iUnitReady), .iUnitQuot(iUnitQuot), .iUnitRem(iUnitRem),
    .oUnitStart(oUnitStart), .oUnitAbort(oUnitAbort), .oUnitSigned(oUnitSigned),
    .oUnitA(oUnitA), .oUnitB(oUnitB),
    .oStall(oStall), .oResult(oResult), .oResultValid(oResultValid),
    .oTimeout(oTimeout)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] result;
    int          stalls;
    int          starts;
    int          aborts;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op starting just after a rising edge; returns just after a rising edge.
  //   readyAt : WAIT cycle (1-based) in which the core pulses ready, 0 = never
  //   flushAt : WAIT cycle in which EX is flushed, 0 = no flush
  //   holdN   : cycles iHold is kept high once the result appears
  task automatic runOp(input string tag, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input int readyAt, input int flushAt, input int holdN,
                       input logic [31:0] q, input logic [31:0] r,
                       input logic [31:0] expRes, input int expStalls,
                       input int expStarts, input int expAborts);
    int   stalls = 0, starts = 0, aborts = 0, waitIdx = 0, nextWait = 0, cyc = 0;
    bit   gotValid = 1'b0, flushed = 1'b0;
    exp_t e;
    if (flushAt == 0) begin
      e.result = expRes; e.stalls = expStalls; e.starts = expStarts; e.aborts = expAborts;
      sbQ.push_back(e);
    end
    iEX_Funct3 = f3; iEX_OpA = a; iEX_OpB = b; iEX_DivRem = 1'b1;
    iUnitQuot = q; iUnitRem = r; iUnitReady = 1'b0; iFlush = 1'b0;
    while (!gotValid && !flushed && cyc < 200) begin
      @(negedge iCLK);
      stalls += int'(oStall);
      starts += int'(oUnitStart);
      aborts += int'(oUnitAbort);
      if (oUnitStart) begin
        check({tag, "_unitA"}, oUnitA, a);
        check({tag, "_unitB"}, oUnitB, b);
        check({tag, "_signed"}, {31'b0, oUnitSigned}, {31'b0, ~f3[0]});
      end
      if (oResultValid) gotValid = 1'b1;
      else if (iFlush)  flushed = 1'b1;
      nextWait = oUnitStart ? 1 : ((waitIdx > 0) ? waitIdx + 1 : 0);
      cyc++;
      if (!gotValid && !flushed) begin
        @(posedge iCLK); #1;
        waitIdx    = nextWait;
        // Operands change after acceptance; the DUT must ignore them.
        iEX_OpA    = a ^ 32'h5A5A_5A5A;
        iEX_OpB    = b ^ 32'hA5A5_A5A5;
        iUnitReady = (readyAt != 0) && (waitIdx == readyAt);
        iFlush     = (flushAt != 0) && (waitIdx == flushAt);
      end
    end
    if (gotValid) begin
      e = sbQ.pop_front();
      check({tag, "_result"}, oResult, e.result);
      check({tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
      check({tag, "_starts"}, 32'(starts), 32'(e.starts));
      check({tag, "_aborts"}, 32'(aborts), 32'(e.aborts));
      if (holdN > 0) begin
        iHold = 1'b1;
        for (int h = 0; h < holdN; h++) begin
          @(posedge iCLK);
          @(negedge iCLK);
          check({tag, "_hold_valid"}, {31'b0, oResultValid}, 32'd1);
          check({tag, "_hold_result"}, oResult, e.result);
          if (h == holdN - 1) iHold = 1'b0;
        end
      end
      @(posedge iCLK); #1;
      iEX_DivRem = 1'b0; iUnitReady = 1'b0;
    end else if (flushed) begin
      check({tag, "_flush_aborts"}, 32'(aborts), 32'(expAborts));
      @(posedge iCLK); #1;
      iFlush = 1'b0; iEX_DivRem = 1'b0; iUnitReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge iCLK);
        check({tag, "_flush_novalid"}, {31'b0, oResultValid}, 32'd0);
        @(posedge iCLK); #1;
      end
    end else begin
      check({tag, "_completed"}, {31'b0, gotValid}, 32'd1);
      iEX_DivRem = 1'b0; iUnitReady = 1'b0; iFlush = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    iRST = 1'b1; iEX_DivRem = 1'b0; iEX_Funct3 = 3'b100; iEX_OpA = '0; iEX_OpB = '0;
    iHold = 1'b0; iFlush = 1'b0; iUnitReady = 1'b0; iUnitQuot = '0; iUnitRem = '0;
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;

    @(negedge iCLK);
    check("rst_stall",   {31'b0, oStall},       32'd0);
    check("rst_start",   {31'b0, oUnitStart},   32'd0);
    check("rst_valid",   {31'b0, oResultValid}, 32'd0);
    check("rst_timeout", {31'b0, oTimeout},     32'd0);
    check("rst_result",  oResult,               32'd0);
    check("rst_unitA",   oUnitA,                32'd0);
    @(posedge iCLK); #1;

    // DIVU 100/7, ready on 3rd WAIT cycle, result held two extra cycles.
    runOp("divu_100_7", 3'b101, 32'd100, 32'd7, 3, 0, 2, 32'd14, 32'd2, 32'd14, 5, 1, 0);
    // Divide by zero: REM returns dividend, DIVU returns all ones.
    runOp("rem_by0",  3'b110, 32'hFFFF_FFF9, 32'd0, 0, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFF9, 1, 0, 0);
    runOp("divu_by0", 3'b101, 32'd5,         32'd0, 0, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
    // Signed overflow.
    runOp("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 32'd0, 32'd0, 32'h8000_0000, 1, 0, 0);
    runOp("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 32'd0, 32'd0, 32'd0, 1, 0, 0);
    // Same operands unsigned are not a corner case: the core is used.
    runOp("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0, 32'd0, 32'h8000_0000, 32'd0, 3, 1, 0);

    // DIV then REM on the same operands.
    runOp("div_100_7", 3'b100, 32'd100, 32'd7, 2, 0, 0, 32'd14, 32'd2, 32'd14, 4, 1, 0);
`ifdef DIVREM_REUSE_EN
    runOp("rem_reuse", 3'b110, 32'd100, 32'd7, 1, 0, 0, 32'd99, 32'd99, 32'd2, 1, 0, 0);
`else
    runOp("rem_core",  3'b110, 32'd100, 32'd7, 1, 0, 0, 32'd14, 32'd2, 32'd2, 3, 1, 0);
`endif

    // Flush on 2nd WAIT cycle coinciding with ready: flush wins.
    runOp("div_flush", 3'b100, 32'd50, 32'd5, 2, 2, 0, 32'd10, 32'd0, 32'd0, 0, 1, 1);
    @(negedge iCLK);
    check("pre_wd_timeout", {31'b0, oTimeout}, 32'd0);
    @(posedge iCLK); #1;

    // Core never answers: watchdog after 40 WAIT cycles.
    runOp("divu_wd", 3'b101, 32'd9, 32'd3, 0, 0, 0, 32'd3, 32'd0, 32'd0, 42, 1, 1);
    @(negedge iCLK);
    check("wd_timeout_set", {31'b0, oTimeout}, 32'd1);
    @(posedge iCLK); #1;

    // Watchdog also invalidates any stored result, so the core is used again.
    runOp("div_after_wd", 3'b100, 32'd100, 32'd7, 1, 0, 0, 32'd14, 32'd2, 32'd14, 3, 1, 0);
    @(negedge iCLK);
    check("wd_timeout_sticky", {31'b0, oTimeout}, 32'd1);
    check("sb_empty", 32'(sbQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
